// File: rtl/sync_reg_file.sv
// sync_reg_file - memory-mapped register bank behind the AXI-to-sync converter.
//
// Consumes the converter's single-cycle en/we/addr/wdata strobe and returns
// registered read data one cycle after a read strobe.
//
// Register map (index = addr[63:3], addr[2:0] ignored):
//   0        ID        RO   constant ID_VALUE
//   1        SCRATCH   RW
//   2        CTRL      RW   bit0 counter enable, bit1 counter clear (self-clearing)
//   3        COUNTER   RO   free-running 64-bit cycle counter
//   4        STATUS    W1C  bit0 unmapped write, bit1 unmapped read, bit2 counter wrap
//   5        IRQ_MASK  RW   bits[2:0]
//   8..8+N-1 GP        RW   exported on gp_out
//   others   unmapped  reads return BAD_RDATA
//
// Ports:
//   clk     clock, rising edge
//   reset   synchronous active-high reset
//   en      access strobe, one cycle per access
//   we      1 = write, 0 = read
//   addr    byte address
//   wdata   write data
//   rdata   registered read data, holds until the next read
//   gp_out  GP register contents, GP[i] at [64i+63:64i]
//   irq     OR of STATUS[2:0] & IRQ_MASK[2:0]
module sync_reg_file #(
  parameter int unsigned NUM_GP    = 4,
  parameter logic [63:0] ID_VALUE  = 64'h0000_0001_5EC0_0001,
  parameter logic [63:0] BAD_RDATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   we,
  input  logic [63:0]            addr,
  input  logic [63:0]            wdata,
  output logic [63:0]            rdata,
  output logic [NUM_GP*64-1:0]   gp_out,
  output logic                   irq
);

  localparam logic [60:0] IDX_ID      = 61'd0;
  localparam logic [60:0] IDX_SCRATCH = 61'd1;
  localparam logic [60:0] IDX_CTRL    = 61'd2;
  localparam logic [60:0] IDX_COUNTER = 61'd3;
  localparam logic [60:0] IDX_STATUS  = 61'd4;
  localparam logic [60:0] IDX_MASK    = 61'd5;
  localparam logic [60:0] IDX_GP_LO   = 61'd8;
  localparam logic [60:0] IDX_GP_END  = 61'(8 + NUM_GP);

  logic [63:0]          rdata_q,   rdata_d;
  logic [63:0]          scratch_q, scratch_d;
  logic [63:0]          ctrl_q,    ctrl_d;
  logic [63:0]          counter_q, counter_d;
  logic [2:0]           status_q,  status_d;
  logic [2:0]           mask_q,    mask_d;
  logic [NUM_GP*64-1:0] gp_q,      gp_d;

  logic [60:0] idx;
  logic        wr, rd, is_gp, mapped;
  logic        ctr_clr, ctr_wrap;
  logic [2:0]  status_set, status_clr;
  logic [63:0] gp_rd;
  logic        unused_addr_lsbs;

  assign idx              = addr[63:3];
  assign unused_addr_lsbs = ^addr[2:0];
  assign wr               = en & we;
  assign rd               = en & ~we;
  assign is_gp            = (idx >= IDX_GP_LO) && (idx < IDX_GP_END);
  assign mapped           = (idx <= IDX_MASK) || is_gp;

  // Clear is a write strobe, not stored state, so it wins over the increment
  // that the already-registered enable would otherwise cause at the same edge.
  assign ctr_clr  = wr && (idx == IDX_CTRL) && wdata[1];
  assign ctr_wrap = ctrl_q[0] && !ctr_clr && (&counter_q);

  always_comb begin
    gp_rd = '0;
    for (int unsigned i = 0; i < NUM_GP; i++) begin
      if (idx[2:0] == 3'(i)) gp_rd = gp_q[i*64 +: 64];
    end
  end

  always_comb begin
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    gp_d      = gp_q;
    if (wr) begin
      if (idx == IDX_SCRATCH) scratch_d = wdata;
      if (idx == IDX_CTRL)    ctrl_d    = {wdata[63:2], 1'b0, wdata[0]};
      if (idx == IDX_MASK)    mask_d    = wdata[2:0];
      for (int unsigned i = 0; i < NUM_GP; i++) begin
        if (is_gp && (idx[2:0] == 3'(i))) gp_d[i*64 +: 64] = wdata;
      end
    end
  end

  always_comb begin
    counter_d = counter_q;
    if (ctr_clr)        counter_d = '0;
    else if (ctrl_q[0]) counter_d = counter_q + 64'd1;
  end

  // Set terms are ORed after the W1C mask so a coincident set survives the clear.
  always_comb begin
    status_set = {ctr_wrap, rd && !mapped, wr && !mapped};
    status_clr = (wr && (idx == IDX_STATUS)) ? wdata[2:0] : '0;
    status_d   = (status_q & ~status_clr) | status_set;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      if (!mapped)                  rdata_d = BAD_RDATA;
      else if (idx == IDX_ID)       rdata_d = ID_VALUE;
      else if (idx == IDX_SCRATCH)  rdata_d = scratch_q;
      else if (idx == IDX_CTRL)     rdata_d = ctrl_q;
      else if (idx == IDX_COUNTER)  rdata_d = counter_q;
      else if (idx == IDX_STATUS)   rdata_d = {61'd0, status_q};
      else if (idx == IDX_MASK)     rdata_d = {61'd0, mask_q};
      else                          rdata_d = gp_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= '0;
      scratch_q <= '0;
      ctrl_q    <= '0;
      counter_q <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      gp_q      <= '0;
    end else begin
      rdata_q   <= rdata_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      counter_q <= counter_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      gp_q      <= gp_d;
    end
  end

  assign rdata  = rdata_q;
  assign gp_out = gp_q;
  assign irq    = |(status_q & mask_q);

endmodule

// File: tb/tb_sync_reg_file.sv
// tb_sync_reg_file - self-checking bench for sync_reg_file.
// Reads push their expected data to a scoreboard queue when driven and are
// popped and compared one edge later; a small register model supplies all
// expected values.
module tb_sync_reg_file;

  localparam int unsigned NUM_GP    = 4;
  localparam logic [63:0] ID_VALUE  = 64'h0000_0001_5EC0_0001;
  localparam logic [63:0] BAD_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;

  logic                 clk = 1'b0;
  logic                 reset, en, we;
  logic [63:0]          addr, wdata, rdata;
  logic [NUM_GP*64-1:0] gp_out;
  logic                 irq;

  sync_reg_file #(
    .NUM_GP    (NUM_GP),
    .ID_VALUE  (ID_VALUE),
    .BAD_RDATA (BAD_RDATA)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .gp_out (gp_out),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } sb_t;
  sb_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Register model
  logic [63:0] m_scratch, m_ctrl, m_counter, m_rdata;
  logic [2:0]  m_status, m_mask;
  logic [63:0] m_gp [8];

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scratch = '0; m_ctrl = '0; m_counter = '0; m_rdata = '0;
    m_status  = '0; m_mask = '0;
    for (int i = 0; i < 8; i++) m_gp[i] = '0;
  endtask

  task automatic model_step(input string tag, input logic e, input logic w,
                            input logic [63:0] a, input logic [63:0] d);
    logic [60:0] ix;
    logic        mp, rdx, wrx, clr_ctr, wrap;
    logic [2:0]  set, clr;
    logic [63:0] v;
    ix  = a[63:3];
    mp  = (ix < 61'd6) || ((ix >= 61'd8) && (ix < 61'(8 + NUM_GP)));
    rdx = e && !w;
    wrx = e && w;
    if (rdx) begin
      if (!mp) v = BAD_RDATA;
      else begin
        case (ix)
          61'd0:   v = ID_VALUE;
          61'd1:   v = m_scratch;
          61'd2:   v = m_ctrl;
          61'd3:   v = m_counter;
          61'd4:   v = {61'd0, m_status};
          61'd5:   v = {61'd0, m_mask};
          default: v = m_gp[int'(ix) - 8];
        endcase
      end
      sb.push_back('{tag, v});
      m_rdata = v;
    end
    clr_ctr = wrx && (ix == 61'd2) && d[1];
    wrap    = m_ctrl[0] && !clr_ctr && (m_counter == 64'hFFFF_FFFF_FFFF_FFFF);
    if (clr_ctr)        m_counter = '0;
    else if (m_ctrl[0]) m_counter = m_counter + 64'd1;
    set      = {wrap, rdx && !mp, wrx && !mp};
    clr      = (wrx && (ix == 61'd4)) ? d[2:0] : 3'd0;
    m_status = (m_status & ~clr) | set;
    if (wrx && mp) begin
      case (ix)
        61'd1:   m_scratch = d;
        61'd2:   m_ctrl    = d & ~64'h2;
        61'd5:   m_mask    = d[2:0];
        61'd0, 61'd3, 61'd4: ;
        default: m_gp[int'(ix) - 8] = d;
      endcase
    end
  endtask

  function automatic logic [NUM_GP*64-1:0] gp_exp();
    logic [NUM_GP*64-1:0] r;
    for (int i = 0; i < NUM_GP; i++) r[i*64 +: 64] = m_gp[i];
    return r;
  endfunction

  // One bus cycle: drive after a falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input string tag, input logic e, input logic w,
                     input logic [63:0] a, input logic [63:0] d);
    sb_t item;
    en = e; we = w; addr = a; wdata = d;
    model_step(tag, e, w, a, d);
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      item = sb.pop_front();
      check_eq(item.tag, rdata, item.val);
    end else begin
      check_eq({tag, "_rdata_hold"}, rdata, m_rdata);
    end
    check_eq({tag, "_irq"}, irq, |(m_status & m_mask));
    check_eq({tag, "_gp"}, gp_out, gp_exp());
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic do_reset(input logic e, input logic w, input logic [63:0] a, input logic [63:0] d);
    reset = 1'b1; en = e; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    model_reset();
    check_eq("rst_rdata", rdata, 64'd0);
    check_eq("rst_irq", irq, 1'b0);
    check_eq("rst_gp", gp_out, '0);
    @(negedge clk);
    reset = 1'b0; en = 1'b0; we = 1'b0;
  endtask

  task automatic preload_counter_ones();
    force dut.counter_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.counter_q;
    m_counter = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    model_reset();
    @(negedge clk);
    do_reset(1'b0, 1'b0, 64'd0, 64'd0);

    // ID register: constant, writes ignored without status
    cyc("id_rd",       1, 0, 64'h00, 0);
    cyc("id_wr",       1, 1, 64'h00, 64'h1234);
    cyc("id_rd2",      1, 0, 64'h00, 0);
    cyc("status_zero", 1, 0, 64'h20, 0);

    // SCRATCH and GP, with ignored low address bits
    cyc("scr_wr", 1, 1, 64'h08, 64'hA5A5_0000_FFFF_1111);
    cyc("scr_rd", 1, 0, 64'h08, 0);
    cyc("gp0_wr", 1, 1, 64'h40, 64'd5);
    cyc("gp0_rd", 1, 0, 64'h44, 0);
    cyc("gp3_wr", 1, 1, 64'h58, 64'hCAFE_0000_1234_5678);
    cyc("gp3_rd", 1, 0, 64'h5F, 0);
    cyc("gp_past_end_rd", 1, 0, 64'h60, 0);
    cyc("st_w1c_rd", 1, 1, 64'h20, 64'h7);

    // Counter enable, exact count, clear-with-enable
    cyc("ctrl_en", 1, 1, 64'h10, 64'd1);
    repeat (10) cyc("idle", 0, 0, 0, 0);
    cyc("ctr_rd", 1, 0, 64'h18, 0);
    check_eq("ctr_window", (rdata >= 64'd10) && (rdata <= 64'd11), 1'b1);
    cyc("ctr_wr_ignored", 1, 1, 64'h18, 64'hFFFF);
    cyc("ctrl_clr_en", 1, 1, 64'h10, 64'hF0F0_0000_0000_0003);
    cyc("ctr_rd_after_clr", 1, 0, 64'h18, 0);
    cyc("ctrl_rd", 1, 0, 64'h10, 0);
    cyc("ctrl_off", 1, 1, 64'h10, 64'd0);

    // Unmapped accesses, sticky status, mask and W1C
    cyc("unm_rd", 1, 0, 64'h30, 0);
    cyc("st_rd2", 1, 0, 64'h20, 0);
    cyc("unm_wr", 1, 1, 64'h38, 64'h1);
    cyc("st_rd3", 1, 0, 64'h20, 0);
    cyc("mask_wr2", 1, 1, 64'h28, 64'h2);
    cyc("mask_rd", 1, 0, 64'h28, 0);
    cyc("st_w1c2", 1, 1, 64'h20, 64'h2);
    cyc("st_rd1", 1, 0, 64'h20, 0);
    cyc("st_w1c1", 1, 1, 64'h20, 64'h1);

    // Counter wrap from a preloaded all-ones value
    cyc("mask_wr4", 1, 1, 64'h28, 64'hFFFF_FFFF_FFFF_FFFC);
    preload_counter_ones();
    cyc("ctr_rd_ones", 1, 0, 64'h18, 0);
    cyc("ctrl_en2", 1, 1, 64'h10, 64'd1);
    cyc("wrap_idle", 0, 0, 0, 0);
    cyc("ctr_rd_wrapped", 1, 0, 64'h18, 0);
    cyc("st_rd_wrap", 1, 0, 64'h20, 0);
    cyc("st_w1c4", 1, 1, 64'h20, 64'h4);

    // Wrap coincident with W1C of the same bit: set wins
    @(negedge clk);
    preload_counter_ones();
    cyc("st_w1c_on_wrap", 1, 1, 64'h20, 64'h4);
    cyc("st_rd_setwins", 1, 0, 64'h20, 0);
    cyc("ctrl_off2", 1, 1, 64'h10, 64'd0);

    // Reset coincident with a SCRATCH write
    cyc("unm_rd_pre_rst", 1, 0, 64'h70, 0);
    do_reset(1'b1, 1'b1, 64'h08, 64'h1111_2222_3333_4444);
    cyc("scr_rd_after_rst", 1, 0, 64'h08, 0);
    cyc("st_rd_after_rst",  1, 0, 64'h20, 0);
    cyc("ctr_rd_after_rst", 1, 0, 64'h18, 0);

    check_eq("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
